// File: rtl/counter_general_axil_slave_pkg.sv
// Shared definitions for the AXI4-Lite counter block:
// register offsets, control bits, responses, write FSM.
package counter_general_pkg;

  localparam int AXI_DW = 32;
  localparam int AXI_AW = 5;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESCALE = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_SCRATCH  = 3'd3;
  localparam logic [2:0] ADDR_COUNT    = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IRQ  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wstate_t;

  function automatic logic [31:0] apply_strb(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic wr_ok(input logic [2:0] idx);
    return (idx <= ADDR_SCRATCH) || (idx == ADDR_STATUS);
  endfunction

  function automatic logic rd_ok(input logic [2:0] idx);
    return idx <= ADDR_STATUS;
  endfunction

endpackage

// File: rtl/counter_general_axil_slave_if.sv
// AXI4-Lite bus bundle between the master VIP
// and the counter register slave.
interface counter_general_axil_slave_if;
  import counter_general_pkg::*;

  logic [AXI_AW-1:0] S_AXI_AWADDR;
  logic [2:0]        S_AXI_AWPROT;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [AXI_DW-1:0] S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [AXI_AW-1:0] S_AXI_ARADDR;
  logic [2:0]        S_AXI_ARPROT;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [AXI_DW-1:0] S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

endinterface

// File: rtl/counter_general_axil_slave_core.sv
// Prescaled up-counter with period wrap and
// one-shot auto-stop request.
module counter_general_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_auto_reload,
  input  logic [31:0] i_prescale,
  input  logic [31:0] i_period,
  input  logic        i_restart,
  output logic [31:0] o_count,
  output logic        o_wrap_pulse,
  output logic        o_stop_pulse
);

  logic [31:0] r_pre;
  logic [31:0] r_count;
  logic        w_tick;

  // a restart suppresses the tick so no wrap can
  // escape on the edge that zeroes the counter
  assign w_tick = i_enable && !i_restart &&
                  (r_pre == i_prescale);

  assign o_wrap_pulse = w_tick && (r_count == i_period);
  assign o_stop_pulse = o_wrap_pulse && !i_auto_reload;
  assign o_count      = r_count;

  // prescaler and count; enable=0 freezes both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_count <= '0;
    end else if (i_restart) begin
      r_pre   <= '0;
      r_count <= '0;
    end else if (i_enable) begin
      r_pre <= w_tick ? 32'd0 : r_pre + 32'd1;
      if (w_tick)
        r_count <= (r_count == i_period) ?
                   32'd0 : r_count + 32'd1;
    end
  end

endmodule

// File: rtl/counter_general_axil_slave.sv
// AXI4-Lite register front end for the general
// counter: config regs, count/status, level irq.
module counter_general_axil_slave
  import counter_general_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic ACLK,
  input  logic ARESETN,
  counter_general_axil_slave_if.slave s_axi,
  output logic irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  logic [31:0] r_ctrl;
  logic [31:0] r_prescale;
  logic [31:0] r_period;
  logic [31:0] r_scratch;
  logic        r_status;

  wstate_t     r_wstate;
  logic [AW-1:0] r_awaddr;
  logic [DW-1:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;

  logic        r_arready;
  logic        r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [1:0]  r_rresp;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_wr_fire;
  logic [AW-1:0] w_wr_addr;
  logic [DW-1:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic [2:0]  w_wr_idx;
  logic        w_wr_ok;
  logic        w_wr_en;
  logic        w_restart;
  logic [2:0]  w_rd_idx;
  logic [DW-1:0] w_rd_data;
  logic [1:0]  w_rd_resp;
  logic [31:0] w_count;
  logic        w_wrap;
  logic        w_stop;
  logic        w_unused_ok;

  assign w_aw_hs = s_axi.S_AXI_AWVALID && r_awready;
  assign w_w_hs  = s_axi.S_AXI_WVALID  && r_wready;
  assign w_ar_hs = s_axi.S_AXI_ARVALID && r_arready;

  // the write commits on the edge where the second
  // half arrives, so pick each half from latch or bus
  always_comb begin
    w_wr_fire = 1'b0;
    case (r_wstate)
      W_IDLE:      w_wr_fire = w_aw_hs && w_w_hs;
      W_HAVE_ADDR: w_wr_fire = w_w_hs;
      W_HAVE_DATA: w_wr_fire = w_aw_hs;
      default:     w_wr_fire = 1'b0;
    endcase
  end

  assign w_wr_addr = (r_wstate == W_HAVE_ADDR) ?
                     r_awaddr : s_axi.S_AXI_AWADDR;
  assign w_wr_data = (r_wstate == W_HAVE_DATA) ?
                     r_wdata : s_axi.S_AXI_WDATA;
  assign w_wr_strb = (r_wstate == W_HAVE_DATA) ?
                     r_wstrb : s_axi.S_AXI_WSTRB;
  assign w_wr_idx  = w_wr_addr[4:2];
  assign w_wr_ok   = wr_ok(w_wr_idx);
  assign w_wr_en   = w_wr_fire && w_wr_ok;
  assign w_restart = w_wr_en &&
                     ((w_wr_idx == ADDR_PRESCALE) ||
                      (w_wr_idx == ADDR_PERIOD));

  // write channel FSM with registered handshakes
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (w_wr_fire) begin
      r_wstate  <= W_RESP;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr  <= s_axi.S_AXI_AWADDR;
            r_wstate  <= W_HAVE_ADDR;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
          end else if (w_w_hs) begin
            r_wdata   <= s_axi.S_AXI_WDATA;
            r_wstrb   <= s_axi.S_AXI_WSTRB;
            r_wstate  <= W_HAVE_DATA;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
          end else begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            r_bvalid  <= 1'b0;
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // register file; software CTRL write beats auto-stop,
  // hardware wrap beats W1C
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_period   <= '0;
      r_scratch  <= '0;
      r_status   <= 1'b0;
    end else begin
      if (w_wr_en && w_wr_idx == ADDR_CTRL)
        r_ctrl <= apply_strb(r_ctrl, w_wr_data, w_wr_strb);
      else if (w_stop)
        r_ctrl[CTRL_EN] <= 1'b0;
      if (w_wr_en && w_wr_idx == ADDR_PRESCALE)
        r_prescale <= apply_strb(r_prescale, w_wr_data,
                                 w_wr_strb);
      if (w_wr_en && w_wr_idx == ADDR_PERIOD)
        r_period <= apply_strb(r_period, w_wr_data,
                               w_wr_strb);
      if (w_wr_en && w_wr_idx == ADDR_SCRATCH)
        r_scratch <= apply_strb(r_scratch, w_wr_data,
                                w_wr_strb);
      if (w_wrap)
        r_status <= 1'b1;
      else if (w_wr_en && w_wr_idx == ADDR_STATUS &&
               w_wr_strb[0] && w_wr_data[0])
        r_status <= 1'b0;
    end
  end

  assign w_rd_idx = s_axi.S_AXI_ARADDR[4:2];

  // read data mux; unmapped words return zero
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = rd_ok(w_rd_idx) ? RESP_OKAY : RESP_SLVERR;
    case (w_rd_idx)
      ADDR_CTRL:     w_rd_data = r_ctrl;
      ADDR_PRESCALE: w_rd_data = r_prescale;
      ADDR_PERIOD:   w_rd_data = r_period;
      ADDR_SCRATCH:  w_rd_data = r_scratch;
      ADDR_COUNT:    w_rd_data = w_count;
      ADDR_STATUS:   w_rd_data = {31'd0, r_status};
      default:       w_rd_data = '0;
    endcase
  end

  // read channel: one outstanding read, data held
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else if (r_rvalid) begin
      if (s_axi.S_AXI_RREADY) begin
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
      end
    end else if (w_ar_hs) begin
      r_rvalid  <= 1'b1;
      r_arready <= 1'b0;
      r_rdata   <= w_rd_data;
      r_rresp   <= w_rd_resp;
    end else begin
      r_arready <= 1'b1;
    end
  end

  counter_general_core u_core (
    .clk           (ACLK),
    .rst_n         (ARESETN),
    .i_enable      (r_ctrl[CTRL_EN]),
    .i_auto_reload (r_ctrl[CTRL_AUTO]),
    .i_prescale    (r_prescale),
    .i_period      (r_period),
    .i_restart     (w_restart),
    .o_count       (w_count),
    .o_wrap_pulse  (w_wrap),
    .o_stop_pulse  (w_stop)
  );

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;

  assign irq = r_status && r_ctrl[CTRL_IRQ];

  assign w_unused_ok = ^{s_axi.S_AXI_AWPROT,
                         s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_ARADDR[1:0],
                         w_wr_addr[1:0]};

endmodule

// File: tb/tb_counter_general_axil_slave.sv
// Self-checking bench for the AXI4-Lite counter slave:
// vector table plus scoreboard and corner sequences.
module tb_counter_general_axil_slave;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic ACLK;
  logic ARESETN;
  logic irq;

  counter_general_axil_slave_if vif();

  counter_general_axil_slave dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s_axi   (vif),
    .irq     (irq)
  );

  int n_vec = 0;
  int n_err = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout, got none required handshake", nm);
  endtask

  function automatic vec_t mkw(input logic [4:0] a,
                               input logic [31:0] d,
                               input logic [3:0] s,
                               input logic [1:0] r);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.data = d; v.strb = s;
    v.exp_data = '0; v.exp_resp = r;
    return v;
  endfunction

  function automatic vec_t mkr(input logic [4:0] a,
                               input logic [31:0] d,
                               input logic [1:0] r);
    vec_t v;
    v.wr = 1'b0; v.addr = a; v.data = '0; v.strb = '0;
    v.exp_data = d; v.exp_resp = r;
    return v;
  endfunction

  task automatic axi_write(input logic [4:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s,
                           output logic [1:0] r);
    bit aw_done, w_done, aw_go, w_go;
    int n;
    r = 2'bxx;
    aw_done = 0; w_done = 0; n = 0;
    @(negedge ACLK);
    vif.S_AXI_AWADDR  = a;
    vif.S_AXI_AWVALID = 1'b1;
    vif.S_AXI_WDATA   = d;
    vif.S_AXI_WSTRB   = s;
    vif.S_AXI_WVALID  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_go = vif.S_AXI_AWVALID && vif.S_AXI_AWREADY;
      w_go  = vif.S_AXI_WVALID && vif.S_AXI_WREADY;
      @(negedge ACLK);
      n++;
      if (aw_go) begin vif.S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_go)  begin vif.S_AXI_WVALID = 1'b0; w_done = 1; end
    end
    if (!(aw_done && w_done)) begin
      vif.S_AXI_AWVALID = 1'b0;
      vif.S_AXI_WVALID  = 1'b0;
      timeout("aw_w");
      return;
    end
    vif.S_AXI_BREADY = 1'b1;
    n = 0;
    while (!vif.S_AXI_BVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!vif.S_AXI_BVALID) begin
      vif.S_AXI_BREADY = 1'b0;
      timeout("b");
      return;
    end
    r = vif.S_AXI_BRESP;
    @(negedge ACLK);
    vif.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a,
                          output logic [31:0] d,
                          output logic [1:0] r);
    int n;
    d = 'x; r = 2'bxx;
    @(negedge ACLK);
    vif.S_AXI_ARADDR  = a;
    vif.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!vif.S_AXI_ARREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!vif.S_AXI_ARREADY) begin
      vif.S_AXI_ARVALID = 1'b0;
      timeout("ar");
      return;
    end
    @(negedge ACLK);
    vif.S_AXI_ARVALID = 1'b0;
    vif.S_AXI_RREADY  = 1'b1;
    n = 0;
    while (!vif.S_AXI_RVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!vif.S_AXI_RVALID) begin
      vif.S_AXI_RREADY = 1'b0;
      timeout("r");
      return;
    end
    d = vif.S_AXI_RDATA;
    r = vif.S_AXI_RRESP;
    @(negedge ACLK);
    vif.S_AXI_RREADY = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    logic [31:0] d;
    logic [1:0]  r;
    vec_t e;
    exp_q.push_back(v);
    if (v.wr) axi_write(v.addr, v.data, v.strb, r);
    else      axi_read(v.addr, d, r);
    e = exp_q.pop_front();
    if (e.wr) begin
      chk($sformatf("bresp@%h", e.addr), {30'd0, r},
          {30'd0, e.exp_resp});
    end else begin
      chk($sformatf("rresp@%h", e.addr), {30'd0, r},
          {30'd0, e.exp_resp});
      chk($sformatf("rdata@%h", e.addr), d, e.exp_data);
    end
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  logic [31:0] prev, cur;
  logic [1:0]  br;
  int since, nchg, n;
  bit wrapped, moved;

  initial begin
    ARESETN = 1'b0;
    vif.S_AXI_AWADDR = '0; vif.S_AXI_AWPROT = '0;
    vif.S_AXI_AWVALID = 1'b0;
    vif.S_AXI_WDATA = '0; vif.S_AXI_WSTRB = '0;
    vif.S_AXI_WVALID = 1'b0;
    vif.S_AXI_BREADY = 1'b0;
    vif.S_AXI_ARADDR = '0; vif.S_AXI_ARPROT = '0;
    vif.S_AXI_ARVALID = 1'b0;
    vif.S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rst_bvalid", {31'd0, vif.S_AXI_BVALID}, 0);
    chk("rst_rvalid", {31'd0, vif.S_AXI_RVALID}, 0);
    chk("rst_awready", {31'd0, vif.S_AXI_AWREADY}, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    ARESETN = 1'b1;

    // reset readback
    for (int a = 0; a < 6; a++)
      tbl.push_back(mkr(5'(a * 4), 32'd0, OK));
    run_tbl();
    chk("irq_after_rst", {31'd0, irq}, 0);

    // full-width RW with enable left off
    tbl.push_back(mkw(5'h00, 32'hFFFF_FFF2, 4'hF, OK));
    tbl.push_back(mkw(5'h04, 32'h2, 4'hF, OK));
    tbl.push_back(mkw(5'h08, 32'h3, 4'hF, OK));
    tbl.push_back(mkw(5'h0C, 32'h4, 4'hF, OK));
    tbl.push_back(mkr(5'h00, 32'hFFFF_FFF2, OK));
    tbl.push_back(mkr(5'h04, 32'h2, OK));
    tbl.push_back(mkr(5'h08, 32'h3, OK));
    tbl.push_back(mkr(5'h0C, 32'h4, OK));
    tbl.push_back(mkr(5'h10, 32'h0, OK));
    tbl.push_back(mkr(5'h14, 32'h0, OK));
    // errors and strobes
    tbl.push_back(mkw(5'h18, 32'h5555_5555, 4'hF, ERR));
    tbl.push_back(mkw(5'h10, 32'h0000_0009, 4'hF, ERR));
    tbl.push_back(mkr(5'h10, 32'h0, OK));
    tbl.push_back(mkr(5'h18, 32'h0, ERR));
    tbl.push_back(mkr(5'h1C, 32'h0, ERR));
    tbl.push_back(mkw(5'h0C, 32'h0, 4'hF, OK));
    tbl.push_back(mkw(5'h0C, 32'hAABB_CCDD, 4'b0101, OK));
    tbl.push_back(mkr(5'h0C, 32'h00BB_00DD, OK));
    tbl.push_back(mkw(5'h00, 32'h0, 4'hF, OK));
    run_tbl();

    // count/wrap with prescale 1, period 3
    tbl.push_back(mkw(5'h04, 32'h1, 4'hF, OK));
    tbl.push_back(mkw(5'h08, 32'h3, 4'hF, OK));
    tbl.push_back(mkw(5'h00, 32'h7, 4'hF, OK));
    run_tbl();
    prev = dut.w_count;
    since = 0; nchg = 0; wrapped = 0;
    for (int c = 0; c < 40 && !wrapped; c++) begin
      @(negedge ACLK);
      since++;
      cur = dut.w_count;
      if (cur != prev) begin
        chk("count_step", cur, (prev == 3) ? 32'd0 : prev + 1);
        if (nchg > 0) chk("count_interval", since, 2);
        nchg++;
        if (cur == 0) begin
          chk("irq_on_wrap", {31'd0, irq}, 1);
          chk("wrap_steps", nchg, 4);
          wrapped = 1;
        end
        since = 0;
        prev = cur;
      end
    end
    if (!wrapped) timeout("wrap");
    tbl.push_back(mkw(5'h00, 32'h6, 4'hF, OK));
    tbl.push_back(mkr(5'h14, 32'h1, OK));
    tbl.push_back(mkw(5'h14, 32'h1, 4'h0, OK));
    run_tbl();
    chk("irq_w1c_nostrb", {31'd0, irq}, 1);
    apply(mkw(5'h14, 32'h1, 4'hF, OK));
    chk("irq_cleared", {31'd0, irq}, 0);
    apply(mkr(5'h14, 32'h0, OK));

    // one-shot: prescale 0, period 2, enable only
    tbl.push_back(mkw(5'h04, 32'h0, 4'hF, OK));
    tbl.push_back(mkw(5'h08, 32'h2, 4'hF, OK));
    tbl.push_back(mkw(5'h00, 32'h1, 4'hF, OK));
    run_tbl();
    repeat (6) @(negedge ACLK);
    moved = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      if (dut.w_count != 0) moved = 1;
    end
    chk("oneshot_rest", {31'd0, moved}, 0);
    tbl.push_back(mkr(5'h00, 32'h0, OK));
    tbl.push_back(mkr(5'h10, 32'h0, OK));
    tbl.push_back(mkr(5'h14, 32'h1, OK));
    run_tbl();
    chk("oneshot_irq", {31'd0, irq}, 0);

    // W three cycles before AW, BREADY held off
    n = 0;
    @(negedge ACLK);
    while (!vif.S_AXI_WREADY && n < 10) begin
      @(negedge ACLK);
      n++;
    end
    vif.S_AXI_WDATA  = 32'h1234_5678;
    vif.S_AXI_WSTRB  = 4'hF;
    vif.S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    vif.S_AXI_WVALID = 1'b0;
    chk("w_first_wready", {31'd0, vif.S_AXI_WREADY}, 0);
    chk("w_first_awready", {31'd0, vif.S_AXI_AWREADY}, 1);
    repeat (2) @(negedge ACLK);
    vif.S_AXI_AWADDR  = 5'h0C;
    vif.S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    vif.S_AXI_AWVALID = 1'b0;
    vif.S_AXI_WDATA   = 32'hDEAD_BEEF;
    vif.S_AXI_WVALID  = 1'b1;
    br = vif.S_AXI_BRESP;
    for (int c = 0; c < 5; c++) begin
      chk("hold_bvalid", {31'd0, vif.S_AXI_BVALID}, 1);
      chk("hold_bresp", {30'd0, vif.S_AXI_BRESP}, {30'd0, br});
      chk("hold_awready", {31'd0, vif.S_AXI_AWREADY}, 0);
      chk("hold_wready", {31'd0, vif.S_AXI_WREADY}, 0);
      @(negedge ACLK);
    end
    chk("late_bresp", {30'd0, br}, {30'd0, OK});
    vif.S_AXI_WVALID = 1'b0;
    vif.S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    vif.S_AXI_BREADY = 1'b0;
    chk("b_done", {31'd0, vif.S_AXI_BVALID}, 0);
    apply(mkr(5'h0C, 32'h1234_5678, OK));

    // reset with an address latched
    vif.S_AXI_AWADDR  = 5'h0C;
    vif.S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    vif.S_AXI_AWVALID = 1'b0;
    chk("mid_awready", {31'd0, vif.S_AXI_AWREADY}, 0);
    #2 ARESETN = 1'b0;
    #1;
    chk("rst_async_bvalid", {31'd0, vif.S_AXI_BVALID}, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      chk("post_rst_bvalid", {31'd0, vif.S_AXI_BVALID}, 0);
    end
    apply(mkr(5'h0C, 32'h0, OK));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
